bip_run_controller: RTL

//  Execution sequencer for the BIP cpu. Gates cpu execution (run / single-step), stops on HLT and counts executed cycles.

---
 rtl/bip_run_controller_if.sv | 54 +++++
 rtl/bip_run_controller.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bip_run_controller_if.sv
// Signal bundle between the BIP run controller and its surroundings: host command channel,
// cpu data-memory strobes, the datamemory port, the dump stream and status outputs.
// The slave modport is the controller's view; master is the environment's view.
interface bip_run_controller_if #(
  parameter int unsigned NBITS_O   = 11,
  parameter int unsigned NBITS_D   = 16,
  parameter int unsigned NBITS_CNT = 16
);

  // Host command channel
  logic                 i_cmd_valid;
  logic [1:0]           i_cmd;
  logic                 o_cmd_ready;

  // Cpu side
  logic [NBITS_D-1:0]   i_Instruction;
  logic                 o_cpu_enable;
  logic                 i_cpu_Rd;
  logic                 i_cpu_Wr;
  logic [NBITS_O-1:0]   i_cpu_DmAddr;
  logic [NBITS_D-1:0]   i_cpu_InData;

  // Datamemory port
  logic                 o_Rd;
  logic                 o_Wr;
  logic [NBITS_O-1:0]   o_DmAddr;
  logic [NBITS_D-1:0]   o_InData;
  logic [NBITS_D-1:0]   i_OutData;

  // Dump stream
  logic                 o_dump_valid;
  logic [NBITS_O-1:0]   o_dump_addr;
  logic [NBITS_D-1:0]   o_dump_data;
  logic                 i_dump_ready;

  // Status
  logic                 o_halted;
  logic [NBITS_CNT-1:0] o_cycles;

  modport slave (
    input  i_cmd_valid, i_cmd, i_Instruction, i_cpu_Rd, i_cpu_Wr, i_cpu_DmAddr, i_cpu_InData,
    input  i_OutData, i_dump_ready,
    output o_cmd_ready, o_cpu_enable, o_Rd, o_Wr, o_DmAddr, o_InData,
    output o_dump_valid, o_dump_addr, o_dump_data, o_halted, o_cycles
  );

  modport master (
    output i_cmd_valid, i_cmd, i_Instruction, i_cpu_Rd, i_cpu_Wr, i_cpu_DmAddr, i_cpu_InData,
    output i_OutData, i_dump_ready,
    input  o_cmd_ready, o_cpu_enable, o_Rd, o_Wr, o_DmAddr, o_InData,
    input  o_dump_valid, o_dump_addr, o_dump_data, o_halted, o_cycles
  );

endinterface

// File: rtl/bip_run_controller.sv
// Execution sequencer for the BIP cpu. Gates cpu execution (run / single-step), stops on HLT,
// counts executed cycles, and owns the datamemory port so that a dump engine can stream the
// first CELDAS data words out once the cpu is idle or halted.
module bip_run_controller #(
  parameter int unsigned       NBITS_O   = 11,
  parameter int unsigned       NBITS_D   = 16,
  parameter int unsigned       OPCODE    = 5,
  parameter int unsigned       CELDAS    = 10,
  parameter logic [OPCODE-1:0] HLT_OP    = '0,
  parameter int unsigned       NBITS_CNT = 16
) (
  input logic                  i_clk,
  input logic                  i_reset,
  bip_run_controller_if.slave  bus
);

  localparam logic [NBITS_O-1:0] LastIdx = NBITS_O'(CELDAS - 1);

  localparam logic [1:0] CmdRun  = 2'b01;
  localparam logic [1:0] CmdStep = 2'b10;
  localparam logic [1:0] CmdDump = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StStep,
    StHalted,
    StDumpRd,
    StDumpOut
  } ctrlState_e;

  ctrlState_e           state;
  ctrlState_e           retState;
  logic                 cpuEnable;
  logic                 cmdReady;
  logic                 halted;
  logic [NBITS_CNT-1:0] cycles;
  logic [NBITS_O-1:0]   dumpIdx;
  logic                 dumpValid;
  logic [NBITS_O-1:0]   dumpAddr;
  logic [NBITS_D-1:0]   dumpData;

  logic cmdAccept;
  logic isHlt;

  assign cmdAccept = bus.i_cmd_valid & cmdReady;
  assign isHlt     = (bus.i_Instruction[NBITS_D-1 -: OPCODE] == HLT_OP);

  // Sequencer FSM with all outputs registered alongside the state
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= StIdle;
      retState  <= StIdle;
      cpuEnable <= 1'b0;
      cmdReady  <= 1'b1;
      halted    <= 1'b0;
      cycles    <= '0;
      dumpIdx   <= '0;
      dumpValid <= 1'b0;
      dumpAddr  <= '0;
      dumpData  <= '0;
    end else begin
      // Every enabled cycle counts, including the HLT cycle itself; sticks at all-ones
      if (cpuEnable && (cycles != '1)) begin
        cycles <= cycles + NBITS_CNT'(1);
      end

      unique case (state)
        StIdle: begin
          if (cmdAccept) begin
            case (bus.i_cmd)
              CmdRun: begin
                state     <= StRun;
                cpuEnable <= 1'b1;
                cmdReady  <= 1'b0;
              end
              CmdStep: begin
                state     <= StStep;
                cpuEnable <= 1'b1;
                cmdReady  <= 1'b0;
              end
              CmdDump: begin
                state    <= StDumpRd;
                retState <= StIdle;
                cmdReady <= 1'b0;
              end
              default: ;
            endcase
          end
        end

        StRun: begin
          if (isHlt) begin
            state     <= StHalted;
            cpuEnable <= 1'b0;
            halted    <= 1'b1;
            cmdReady  <= 1'b1;
          end
        end

        StStep: begin
          cpuEnable <= 1'b0;
          cmdReady  <= 1'b1;
          if (isHlt) begin
            state  <= StHalted;
            halted <= 1'b1;
          end else begin
            state <= StIdle;
          end
        end

        // RUN/STEP are swallowed here; only reset leaves the halted condition
        StHalted: begin
          if (cmdAccept && (bus.i_cmd == CmdDump)) begin
            state    <= StDumpRd;
            retState <= StHalted;
            cmdReady <= 1'b0;
          end
        end

        StDumpRd: begin
          dumpData  <= bus.i_OutData;
          dumpAddr  <= dumpIdx;
          dumpValid <= 1'b1;
          state     <= StDumpOut;
        end

        StDumpOut: begin
          if (bus.i_dump_ready) begin
            dumpValid <= 1'b0;
            if (dumpIdx == LastIdx) begin
              dumpIdx  <= '0;
              state    <= retState;
              cmdReady <= 1'b1;
            end else begin
              dumpIdx <= dumpIdx + NBITS_O'(1);
              state   <= StDumpRd;
            end
          end
        end

        default: begin
          state     <= StIdle;
          cpuEnable <= 1'b0;
          cmdReady  <= 1'b1;
          dumpValid <= 1'b0;
        end
      endcase
    end
  end

  // Datamemory port mux: cpu passes straight through while enabled, otherwise the dump engine
  always_comb begin
    bus.o_Rd     = 1'b0;
    bus.o_Wr     = 1'b0;
    bus.o_DmAddr = dumpIdx;
    bus.o_InData = '0;
    if (cpuEnable) begin
      bus.o_Rd     = bus.i_cpu_Rd;
      bus.o_Wr     = bus.i_cpu_Wr;
      bus.o_DmAddr = bus.i_cpu_DmAddr;
      bus.o_InData = bus.i_cpu_InData;
    end else if (state == StDumpRd) begin
      bus.o_Rd = 1'b1;
    end
  end

  assign bus.o_cmd_ready  = cmdReady;
  assign bus.o_cpu_enable = cpuEnable;
  assign bus.o_dump_valid = dumpValid;
  assign bus.o_dump_addr  = dumpAddr;
  assign bus.o_dump_data  = dumpData;
  assign bus.o_halted     = halted;
  assign bus.o_cycles     = cycles;

`ifndef SYNTHESIS
  // A write can only reach memory on behalf of the running cpu
  wrOnlyWhenEnabled: assert property (@(posedge i_clk) disable iff (i_reset)
    bus.o_Wr |-> cpuEnable);

  // A stalled dump word must not move
  dumpHoldsWhenStalled: assert property (@(posedge i_clk) disable iff (i_reset)
    (dumpValid && !bus.i_dump_ready) |=> (dumpValid && $stable(dumpAddr) && $stable(dumpData)));

  // cpu and dump engine never share the port
  enableExcludesDump: assert property (@(posedge i_clk) disable iff (i_reset)
    cpuEnable |-> !dumpValid);
`endif

endmodule
